// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw buttons in, conditioned levels and pulses out.
// master drives the raw buttons, slave is the conditioner side.
interface btn_conditioner_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button 2-FF synchronizer and debounce FSM producing a clean level and press/release pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses while a button stays pressed.
module btn_conditioner #(
    parameter int unsigned N_BTN     = 3,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
`endif
) (
    input logic              clk,
    input logic              rst_n,
    btn_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD - 1);
    localparam logic [RptW-1:0] RptOne        = RptW'(1);
`endif

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] release_vec;
    logic [N_BTN-1:0] press_d_vec;
    logic             any_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
`ifdef BTN_AUTOREPEAT_EN
        logic [RptW-1:0]  rpt_q, rpt_d;
        logic             rpt_armed_q, rpt_armed_d;
`endif

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                StReleased: begin
                    if (sync2_q[i]) begin
                        state_d = StPressWait;
                        cnt_d   = CntOne;
                    end
                end
                StPressWait: begin
                    if (!sync2_q[i]) begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end else if (cnt_q == DbLast) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StPressed: begin
                    if (!sync2_q[i]) begin
                        state_d = StReleaseWait;
                        cnt_d   = CntOne;
                    end
                end
                StReleaseWait: begin
                    if (sync2_q[i]) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_q == DbLast) begin
                        state_d   = StReleased;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end
            endcase

`ifdef BTN_AUTOREPEAT_EN
            // Counter only runs while staying in PRESSED; any entry or exit restarts the delay.
            rpt_d       = '0;
            rpt_armed_d = 1'b0;
            if (state_q == StPressed && state_d == StPressed) begin
                rpt_armed_d = rpt_armed_q;
                if (rpt_q == (rpt_armed_q ? RptPeriodLast : RptDelayLast)) begin
                    press_d     = 1'b1;
                    rpt_d       = '0;
                    rpt_armed_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + RptOne;
                end
            end
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= StReleased;
                cnt_q       <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q       <= '0;
                rpt_armed_q <= 1'b0;
`endif
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q       <= rpt_d;
                rpt_armed_q <= rpt_armed_d;
`endif
            end
        end

        assign level_vec[i]   = level_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign press_d_vec[i] = press_d;
    end

    // Registered from the next-state pulses so it lines up with btn_press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |press_d_vec;
        end
    end

    assign bus.btn_level   = level_vec;
    assign bus.btn_press   = press_vec;
    assign bus.btn_release = release_vec;
    assign bus.any_press   = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: table-driven raw patterns, expected pulses scoreboarded
// by absolute cycle and compared every cycle on the falling edge.
module tb_btn_conditioner;

    localparam int unsigned NB         = 3;
    localparam int unsigned DB         = 4;
    localparam int unsigned RPT_DELAY  = 20;
    localparam int unsigned RPT_PERIOD = 8;
    // Raw driven after a falling edge is sampled at the next rising edge k; outputs change at k+1+DB.
    localparam int unsigned LAT = DB + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    btn_conditioner_if #(.N_BTN(NB)) bus ();

    btn_conditioner #(
        .N_BTN(NB),
        .DB_CYCLES(DB),
        .CNT_W(3)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(RPT_DELAY),
        .REPEAT_PERIOD(RPT_PERIOD)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int unsigned   at;
        logic [NB-1:0] mask;
        bit            rel;
    } exp_t;

    typedef struct {
        logic [NB-1:0] raw;
        int unsigned   hold;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        int unsigned   reps;
        string         name;
    } vec_t;

    exp_t          sb[$];
    vec_t          tbl[22];
    logic [NB-1:0] exp_level = '0;
    int            n_checks  = 0;
    int            n_errors  = 0;

    task automatic check(string name, logic [NB-1:0] got, logic [NB-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic push(int unsigned at, logic [NB-1:0] mask, bit rel);
        exp_t e;
        e.at   = at;
        e.mask = mask;
        e.rel  = rel;
        sb.push_back(e);
    endtask

    // One clock: pop whatever is due this cycle and compare every output.
    task automatic tick();
        logic [NB-1:0] ep;
        logic [NB-1:0] er;
        ep = '0;
        er = '0;
        @(negedge clk);
        if (!rst_n) exp_level = '0;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                if (sb[i].rel) er = er | sb[i].mask;
                else           ep = ep | sb[i].mask;
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL stale_expect cyc=%0d got=none want=%b at %0d", cyc, sb[i].mask,
                         sb[i].at);
                sb.delete(i);
            end
        end
        exp_level = (exp_level | ep) & ~er;
        check("btn_press", bus.btn_press, ep);
        check("btn_release", bus.btn_release, er);
        check("btn_level", bus.btn_level, exp_level);
        check("any_press", {{(NB-1){1'b0}}, bus.any_press}, {{(NB-1){1'b0}}, |ep});
    endtask

    task automatic apply(vec_t v);
        bus.btn_raw = v.raw;
        if (v.press != '0) push(cyc + LAT, v.press, 1'b0);
        if (v.rel != '0) push(cyc + LAT, v.rel, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
        for (int r = 0; r < int'(v.reps); r++)
            push(cyc + LAT + RPT_DELAY + RPT_PERIOD * r, v.press, 1'b0);
`endif
        repeat (v.hold) tick();
    endtask

    initial begin
        tbl[0]  = '{3'b000, 12, 3'b000, 3'b111, 0, "release all"};
        tbl[1]  = '{3'b010, 30, 3'b010, 3'b000, 1, "ch1 clean press"};
        tbl[2]  = '{3'b000, 12, 3'b000, 3'b010, 0, "ch1 release"};
        tbl[3]  = '{3'b001, 1, 3'b000, 3'b000, 0, "bounce 1"};
        tbl[4]  = '{3'b001, 1, 3'b000, 3'b000, 0, "bounce 1"};
        tbl[5]  = '{3'b000, 1, 3'b000, 3'b000, 0, "bounce 0"};
        tbl[6]  = '{3'b001, 1, 3'b000, 3'b000, 0, "bounce 1"};
        tbl[7]  = '{3'b001, 1, 3'b000, 3'b000, 0, "bounce 1"};
        tbl[8]  = '{3'b001, 1, 3'b000, 3'b000, 0, "bounce 1"};
        tbl[9]  = '{3'b000, 1, 3'b000, 3'b000, 0, "bounce 0"};
        tbl[10] = '{3'b001, 12, 3'b001, 3'b000, 0, "bounce settles high"};
        tbl[11] = '{3'b000, 12, 3'b000, 3'b001, 0, "ch0 release"};
        tbl[12] = '{3'b100, 12, 3'b100, 3'b000, 0, "ch2 press"};
        tbl[13] = '{3'b000, 3, 3'b000, 3'b000, 0, "ch2 release glitch"};
        tbl[14] = '{3'b100, 12, 3'b000, 3'b000, 0, "ch2 glitch recovered"};
        tbl[15] = '{3'b000, 12, 3'b000, 3'b100, 0, "ch2 release"};
        tbl[16] = '{3'b001, 2, 3'b001, 3'b000, 0, "ch0 press"};
        tbl[17] = '{3'b101, 12, 3'b100, 3'b000, 0, "ch2 press two later"};
        tbl[18] = '{3'b000, 12, 3'b000, 3'b101, 0, "ch0 ch2 release"};
        tbl[19] = '{3'b010, 54, 3'b010, 3'b000, 4, "ch1 long hold"};
        tbl[20] = '{3'b000, 12, 3'b000, 3'b010, 0, "ch1 release"};
        tbl[21] = '{3'b001, 10, 3'b001, 3'b000, 0, "ch0 press before reset"};

        // Buttons already held while in reset: quiet during reset, one press pulse after.
        bus.btn_raw = 3'b111;
        rst_n       = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        push(cyc + LAT, 3'b111, 1'b0);
        repeat (10) tick();

        for (int i = 0; i < 22; i++) apply(tbl[i]);

        // Asynchronous reset mid-cycle while ch0 is pressed clears everything at once.
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("scoreboard_empty", NB'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
